// File: rtl/instruction_issuer.sv
// -----------------------------------------------------------------------------
// instruction_issuer
//
// Initiator side of the instruction valid/ready/done handshake. Instructions
// from decode are buffered in a small FIFO and offered one at a time to a
// single execution unit. After the unit accepts an instruction (valid && ready)
// the issuer waits for the unit's one-cycle done pulse before offering the
// next one, so at most one instruction is outstanding at any time.
//
// Optional feature macro: ISSUER_TIMEOUT_EN
//   defined   : WAIT_DONE is bounded by TIMEOUT_CYCLES; on expiry timeout_o is
//               set (sticky) and the issuer carries on as if done had arrived.
//   undefined : no timeout hardware, timeout_o tied low, WAIT_DONE is unbounded.
//
// Ports:
//   clk_i                clock, rising edge
//   reset_i              asynchronous active-high reset
//   instr_i              instruction word from decode
//   instr_valid_i        instr_i valid
//   instr_ready_o        FIFO can accept (not full)
//   instruction_o        instruction to unit (registered, stable while valid)
//   instruction_valid_o  instruction_o valid
//   unit_ready_i         unit can accept
//   instruction_done_i   unit done pulse (one cycle)
//   busy_o               FIFO non-empty or an instruction offered/outstanding
//   issued_count_o       instructions accepted by the unit (wraps)
//   done_count_o         done pulses accepted (wraps)
//   timeout_o            sticky hang flag
// -----------------------------------------------------------------------------
module instruction_issuer #(
  parameter int INSTRUCTION_LENGTH = 32,
  parameter int FIFO_DEPTH         = 4,
  parameter int COUNT_WIDTH        = 16,
  parameter int TIMEOUT_CYCLES     = 64
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [INSTRUCTION_LENGTH-1:0] instr_i,
  input  logic                          instr_valid_i,
  output logic                          instr_ready_o,
  output logic [INSTRUCTION_LENGTH-1:0] instruction_o,
  output logic                          instruction_valid_o,
  input  logic                          unit_ready_i,
  input  logic                          instruction_done_i,
  output logic                          busy_o,
  output logic [COUNT_WIDTH-1:0]        issued_count_o,
  output logic [COUNT_WIDTH-1:0]        done_count_o,
  output logic                          timeout_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // ---------------------------------------------------------------------------
  // Instruction FIFO. Pointers carry one extra bit so that full and empty can
  // be told apart when the index bits are equal.
  // ---------------------------------------------------------------------------
  logic [INSTRUCTION_LENGTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]                wr_ptr_reg;
  logic [PTR_W:0]                rd_ptr_reg;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          push;
  logic                          pop;
  logic [INSTRUCTION_LENGTH-1:0] fifo_head;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                      (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

  assign instr_ready_o = !fifo_full;
  assign push          = instr_valid_i && !fifo_full;
  // Handshake with the unit; the offered word is the FIFO head, popped here.
  assign pop           = (state_reg == ISSUE) && unit_ready_i;
  assign fifo_head     = fifo_mem[rd_ptr_reg[PTR_W-1:0]];

  // Storage is not reset: contents are only observed through the pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= instr_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Timeout logic (optional)
  // ---------------------------------------------------------------------------
  logic timeout_expired;

`ifdef ISSUER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] wait_cnt_reg;
  logic          timeout_reg;
  logic          timeout_hit;

  // wait_cnt_reg holds the number of WAIT_DONE cycles already completed, so
  // the limit is reached during the TIMEOUT_CYCLES-th WAIT_DONE cycle.
  assign timeout_expired = (state_reg == WAIT_DONE) &&
                           (wait_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
  // A done pulse in the expiry cycle wins: normal completion, no flag.
  assign timeout_hit     = timeout_expired && !instruction_done_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      if ((state_reg == WAIT_DONE) && (state_next == WAIT_DONE)) begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end else begin
        wait_cnt_reg <= '0;
      end
      if (timeout_hit) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_reg;
`else
  logic unused_timeout_cfg;

  assign timeout_expired    = 1'b0;
  assign timeout_o          = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  // ---------------------------------------------------------------------------
  // Issue FSM: next state and per-cycle strobes
  // ---------------------------------------------------------------------------
  logic load_instr;   // capture the next word into instruction_o
  logic done_accept;  // done pulse counted in WAIT_DONE
  logic has_next;     // a word will be at the FIFO head next cycle

  // A word pushed this cycle into an empty FIFO becomes the head next cycle,
  // so it counts as available when leaving WAIT_DONE.
  assign has_next = !fifo_empty || push;

  always_comb begin
    state_next  = state_reg;
    load_instr  = 1'b0;
    done_accept = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = ISSUE;
          load_instr = 1'b1;
        end
      end
      ISSUE: begin
        if (unit_ready_i) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (instruction_done_i) begin
          done_accept = 1'b1;
        end
        if (instruction_done_i || timeout_expired) begin
          if (has_next) begin
            state_next = ISSUE;
            load_instr = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, output word and counters
  // ---------------------------------------------------------------------------
  logic [INSTRUCTION_LENGTH-1:0] instruction_reg;
  logic [COUNT_WIDTH-1:0]        issued_count_reg;
  logic [COUNT_WIDTH-1:0]        done_count_reg;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg        <= IDLE;
      instruction_reg  <= '0;
      issued_count_reg <= '0;
      done_count_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (load_instr) begin
        // When the FIFO is empty the only possible next head is the word
        // being pushed this very cycle.
        instruction_reg <= fifo_empty ? instr_i : fifo_head;
      end
      if (pop) begin
        issued_count_reg <= issued_count_reg + 1'b1;
      end
      if (done_accept) begin
        done_count_reg <= done_count_reg + 1'b1;
      end
    end
  end

  assign instruction_o       = instruction_reg;
  assign instruction_valid_o = (state_reg == ISSUE);
  assign busy_o              = !fifo_empty || (state_reg != IDLE);
  assign issued_count_o      = issued_count_reg;
  assign done_count_o        = done_count_reg;

endmodule

// File: tb/tb_instruction_issuer.sv
// -----------------------------------------------------------------------------
// tb_instruction_issuer
//
// Directed testbench for instruction_issuer. Each scenario task drives its own
// stimulus and compares DUT outputs against hand-computed values. Inputs are
// driven and outputs sampled 1 time unit after the rising clock edge.
// Build with +define+ISSUER_TIMEOUT_EN to exercise the timeout feature.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instruction_issuer;

`ifdef ISSUER_TIMEOUT_EN
  localparam int TO_CYCLES = 8;
`else
  localparam int TO_CYCLES = 64;
`endif

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic [31:0] instr_i = '0;
  logic        instr_valid_i = 1'b0;
  logic        instr_ready_o;
  logic [31:0] instruction_o;
  logic        instruction_valid_o;
  logic        unit_ready_i = 1'b0;
  logic        instruction_done_i = 1'b0;
  logic        busy_o;
  logic [15:0] issued_count_o;
  logic [15:0] done_count_o;
  logic        timeout_o;

  int checks = 0;
  int errors = 0;

  instruction_issuer #(
    .INSTRUCTION_LENGTH(32),
    .FIFO_DEPTH(4),
    .COUNT_WIDTH(16),
    .TIMEOUT_CYCLES(TO_CYCLES)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .instr_i(instr_i),
    .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o),
    .instruction_o(instruction_o),
    .instruction_valid_o(instruction_valid_o),
    .unit_ready_i(unit_ready_i),
    .instruction_done_i(instruction_done_i),
    .busy_o(busy_o),
    .issued_count_o(issued_count_o),
    .done_count_o(done_count_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    instr_valid_i      = 1'b0;
    instr_i            = '0;
    unit_ready_i       = 1'b0;
    instruction_done_i = 1'b0;
    reset_i            = 1'b1;
    step();
    step();
    reset_i            = 1'b0;
    step();
  endtask

  task automatic push(input logic [31:0] w);
    instr_i       = w;
    instr_valid_i = 1'b1;
    step();
    instr_valid_i = 1'b0;
    $display("push instr=0x%08h ready_after=%0b", w, instr_ready_o);
  endtask

  task automatic pulse_done();
    instruction_done_i = 1'b1;
    step();
    instruction_done_i = 1'b0;
    $display("done pulse issued=%0d done=%0d", issued_count_o, done_count_o);
  endtask

  // Bounded wait for instruction_valid_o; an expired bound counts as an error.
  task automatic wait_valid(input string name, input int max_cycles);
    int n;
    n = 0;
    while (!instruction_valid_o && n < max_cycles) begin
      step();
      n++;
    end
    checks++;
    if (instruction_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL %s: instruction_valid_o=%0b required 1 within %0d cycles",
               name, instruction_valid_o, max_cycles);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({instruction_o, instruction_valid_o, busy_o, issued_count_o, done_count_o,
         timeout_o, instr_ready_o} !== {32'h0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_values: instr=0x%08h v=%0b busy=%0b iss=%0d done=%0d to=%0b rdy=%0b required 0/0/0/0/0/0/1",
               instruction_o, instruction_valid_o, busy_o, issued_count_o, done_count_o,
               timeout_o, instr_ready_o);
    end
    $display("reset checked");
  endtask

  task automatic test_single();
    int valid_cycles;
    do_reset();
    unit_ready_i = 1'b1;
    push(32'hA0000001);
    step();  // IDLE -> ISSUE
    checks++;
    if (instruction_valid_o !== 1'b1 || instruction_o !== 32'hA0000001) begin
      errors++;
      $display("FAIL single_issue: v=%0b instr=0x%08h required 1 0xa0000001",
               instruction_valid_o, instruction_o);
    end
    valid_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (instruction_valid_o) valid_cycles++;
      step();
    end
    checks++;
    if (valid_cycles !== 1) begin
      errors++;
      $display("FAIL single_valid_len: valid cycles=%0d required 1", valid_cycles);
    end
    checks++;
    if (issued_count_o !== 16'd1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL single_waiting: iss=%0d busy=%0b required 1 1", issued_count_o, busy_o);
    end
    pulse_done();
    checks++;
    if (issued_count_o !== 16'd1 || done_count_o !== 16'd1 || busy_o !== 1'b0 ||
        instruction_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_done: iss=%0d done=%0d busy=%0b v=%0b required 1 1 0 0",
               issued_count_o, done_count_o, busy_o, instruction_valid_o);
    end
  endtask

  task automatic test_fifo_full();
    logic [31:0] words [4];
    words[0] = 32'h11110000;
    words[1] = 32'h22220001;
    words[2] = 32'h33330002;
    words[3] = 32'h44440003;
    do_reset();
    unit_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push(words[k]);
      checks++;
      if (instr_ready_o !== (k < 3)) begin
        errors++;
        $display("FAIL fifo_ready_%0d: instr_ready_o=%0b required %0b",
                 k, instr_ready_o, (k < 3));
      end
    end
    push(32'hDEADBEEF);  // must be dropped: FIFO full
    checks++;
    if (instr_ready_o !== 1'b0 || instruction_o !== words[0]) begin
      errors++;
      $display("FAIL fifo_fifth_push: rdy=%0b instr=0x%08h required 0 0x%08h",
               instr_ready_o, instruction_o, words[0]);
    end
    unit_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_valid("fifo_order_wait", 10);
      checks++;
      if (instruction_o !== words[k]) begin
        errors++;
        $display("FAIL fifo_order_%0d: instr=0x%08h required 0x%08h",
                 k, instruction_o, words[k]);
      end
      step();  // handshake
      step();
      pulse_done();
      // Back-to-back: next word offered right after done
      if (k < 3) begin
        checks++;
        if (instruction_valid_o !== 1'b1) begin
          errors++;
          $display("FAIL fifo_back_to_back_%0d: v=%0b required 1", k, instruction_valid_o);
        end
      end
    end
    step();
    step();
    checks++;
    if (issued_count_o !== 16'd4 || done_count_o !== 16'd4 || busy_o !== 1'b0 ||
        instruction_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL fifo_final: iss=%0d done=%0d busy=%0b v=%0b required 4 4 0 0",
               issued_count_o, done_count_o, busy_o, instruction_valid_o);
    end
  endtask

  task automatic test_hold();
    do_reset();
    unit_ready_i = 1'b0;
    push(32'h12345678);
    wait_valid("hold_wait", 5);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (instruction_valid_o !== 1'b1 || instruction_o !== 32'h12345678 ||
          issued_count_o !== 16'd0) begin
        errors++;
        $display("FAIL hold_cycle_%0d: v=%0b instr=0x%08h iss=%0d required 1 0x12345678 0",
                 i, instruction_valid_o, instruction_o, issued_count_o);
      end
      step();
    end
    $display("hold checked for 10 cycles");
  endtask

  task automatic test_spurious_done();
    do_reset();
    pulse_done();  // in IDLE
    checks++;
    if (done_count_o !== 16'd0 || issued_count_o !== 16'd0 || busy_o !== 1'b0 ||
        instruction_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL spurious_idle: done=%0d iss=%0d busy=%0b v=%0b required 0 0 0 0",
               done_count_o, issued_count_o, busy_o, instruction_valid_o);
    end
    unit_ready_i = 1'b0;
    push(32'h0BADF00D);
    wait_valid("spurious_wait", 5);
    pulse_done();  // in ISSUE, before handshake
    checks++;
    if (done_count_o !== 16'd0 || issued_count_o !== 16'd0 || instruction_valid_o !== 1'b1 ||
        instruction_o !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL spurious_issue: done=%0d iss=%0d v=%0b instr=0x%08h required 0 0 1 0x0badf00d",
               done_count_o, issued_count_o, instruction_valid_o, instruction_o);
    end
  endtask

  task automatic test_reset_flush();
    do_reset();
    unit_ready_i = 1'b1;
    push(32'hC0000000);
    push(32'hC0000001);
    push(32'hC0000002);  // same edge: handshake of first word
    checks++;
    if (instruction_valid_o !== 1'b0 || issued_count_o !== 16'd1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_setup: v=%0b iss=%0d busy=%0b required 0 1 1",
               instruction_valid_o, issued_count_o, busy_o);
    end
    #1;
    reset_i = 1'b1;  // asynchronous, mid-cycle
    #1;
    checks++;
    if ({instruction_o, instruction_valid_o, busy_o, issued_count_o, done_count_o,
         instr_ready_o} !== {32'h0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1}) begin
      errors++;
      $display("FAIL flush_async: instr=0x%08h v=%0b busy=%0b iss=%0d done=%0d rdy=%0b required 0/0/0/0/0/1",
               instruction_o, instruction_valid_o, busy_o, issued_count_o, done_count_o,
               instr_ready_o);
    end
    step();
    reset_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (instruction_valid_o !== 1'b0 || issued_count_o !== 16'd0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL flush_quiet_%0d: v=%0b iss=%0d busy=%0b required 0 0 0",
                 i, instruction_valid_o, issued_count_o, busy_o);
      end
    end
    push(32'hC0FFEE00);
    wait_valid("flush_new_wait", 5);
    checks++;
    if (instruction_o !== 32'hC0FFEE00) begin
      errors++;
      $display("FAIL flush_new_word: instr=0x%08h required 0xc0ffee00", instruction_o);
    end
  endtask

`ifdef ISSUER_TIMEOUT_EN
  // Sets up WAIT_DONE cycle 8 with one more word queued behind it.
  task automatic timeout_setup();
    do_reset();
    unit_ready_i = 1'b1;
    push(32'hE0000000);
    push(32'hE0000001);
    step();  // handshake -> WAIT_DONE cycle 1
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (timeout_o !== 1'b0 || instruction_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: to=%0b v=%0b required 0 0", timeout_o, instruction_valid_o);
    end
  endtask

  task automatic test_timeout();
    timeout_setup();
    step();
    checks++;
    if (timeout_o !== 1'b1 || done_count_o !== 16'd0 || instruction_valid_o !== 1'b1 ||
        instruction_o !== 32'hE0000001) begin
      errors++;
      $display("FAIL timeout_expire: to=%0b done=%0d v=%0b instr=0x%08h required 1 0 1 0xe0000001",
               timeout_o, done_count_o, instruction_valid_o, instruction_o);
    end
    timeout_setup();
    pulse_done();  // done on the 8th cycle wins
    checks++;
    if (timeout_o !== 1'b0 || done_count_o !== 16'd1 || instruction_valid_o !== 1'b1 ||
        instruction_o !== 32'hE0000001) begin
      errors++;
      $display("FAIL timeout_done_priority: to=%0b done=%0d v=%0b instr=0x%08h required 0 1 1 0xe0000001",
               timeout_o, done_count_o, instruction_valid_o, instruction_o);
    end
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    unit_ready_i = 1'b1;
    push(32'hF0000000);
    step();  // handshake
    for (int i = 0; i < 100; i++) step();
    checks++;
    if (timeout_o !== 1'b0 || busy_o !== 1'b1 || instruction_valid_o !== 1'b0 ||
        done_count_o !== 16'd0) begin
      errors++;
      $display("FAIL no_timeout_wait: to=%0b busy=%0b v=%0b done=%0d required 0 1 0 0",
               timeout_o, busy_o, instruction_valid_o, done_count_o);
    end
    pulse_done();
    checks++;
    if (done_count_o !== 16'd1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout_done: done=%0d busy=%0b required 1 0", done_count_o, busy_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fifo_full();
    test_hold();
    test_spurious_done();
    test_reset_flush();
`ifdef ISSUER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_issuer.md
Name: instruction_issuer

Overview:
- Initiator side of the instruction valid/ready/done handshake used by the execution units, such as the memory access unit.
- Buffers instructions from the decode stage in a small FIFO and presents them one at a time to a single downstream unit.
- Waits for the unit's one-cycle done pulse before issuing the next instruction, so at most one instruction is outstanding.
- Reports issue/completion counts and a hang-detection flag.

Parameters:
INSTRUCTION_LENGTH, 32, width of one instruction word
FIFO_DEPTH, 4, instruction buffer entries (power of two, >=2)
COUNT_WIDTH, 16, width of the issued/done counters
TIMEOUT_CYCLES, 64, max WAIT_DONE cycles before timeout (>=2)

Ports:
clk_i  in  1  clock, rising edge
reset_i  in  1  asynchronous, active-high reset
instr_i  in  INSTRUCTION_LENGTH  instruction from decode
instr_valid_i  in  1  instr_i valid
instr_ready_o  out  1  FIFO can accept (not full)
instruction_o  out  INSTRUCTION_LENGTH  instruction to unit
instruction_valid_o  out  1  instruction_o valid
unit_ready_i  in  1  unit can accept
instruction_done_i  in  1  unit done pulse (1 cycle)
busy_o  out  1  FIFO non-empty or instruction outstanding
issued_count_o  out  COUNT_WIDTH  instructions accepted by unit
done_count_o  out  COUNT_WIDTH  done pulses accepted
timeout_o  out  1  sticky hang flag

Behaviour:
- Interface: one clock, clk_i; reset_i is asynchronous and active-high.
- Reset values: FIFO empty, state IDLE, instruction_o=0, instruction_valid_o=0, busy_o=0, counters=0, timeout_o=0. instr_ready_o=1 once FIFO is empty.
- Asserting reset_i mid-operation flushes the FIFO and abandons any outstanding instruction; no done pulse is awaited after reset.
- Push:
  - Occurs when instr_valid_i && instr_ready_o at a rising edge.
  - instr_ready_o = !full, combinational from registered pointers.
  - Push into a full FIFO is impossible because ready is low; instr_i is not captured.
- No bypass: a pushed word becomes the FIFO head on the next cycle at the earliest.
- FSM states IDLE, ISSUE, WAIT_DONE:
  - IDLE: FIFO non-empty -> ISSUE. instruction_valid_o=0.
  - ISSUE: instruction_valid_o=1; instruction_o = FIFO head, registered, stable while valid.
    - Handshake when instruction_valid_o && unit_ready_i at an edge: pop FIFO, issued_count++, go WAIT_DONE.
    - instruction_valid_o drops in the following cycle.
    - Valid never drops and data never changes before the handshake.
  - WAIT_DONE: instruction_valid_o=0; timeout counter runs.
    - On instruction_done_i=1: done_count++, timeout counter cleared.
    - Then go ISSUE if FIFO non-empty after any same-cycle push, else IDLE.
- Back-to-back issue: the unit raises ready in the same cycle as done, so the next instruction is offered in the cycle after done.
- instruction_done_i in IDLE or ISSUE is spurious: ignored, no counter change.
- Same-cycle push and pop are both performed; occupancy is unchanged.
- Pointer wrap-around is modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit.
- Counters wrap from 2^COUNT_WIDTH-1 to 0 silently.
- busy_o = !empty || state==WAIT_DONE || state==ISSUE.

Optional Feature:
Macro ISSUER_TIMEOUT_EN.
- Defined:
  - A counter increments each WAIT_DONE cycle.
  - When it reaches TIMEOUT_CYCLES without a done pulse, timeout_o is set (sticky until reset) and the FSM returns to IDLE/ISSUE as if done had arrived; done_count is not incremented.
  - A done pulse in that same cycle takes priority: normal completion, timeout_o not set.
- Not defined: no counter logic; timeout_o tied 0; WAIT_DONE waits indefinitely.

Test Plan:
- Reset, push 0xA0000001, unit_ready_i=1, done pulse 4 cycles after issue -> instruction_o=0xA0000001 valid exactly 1 cycle; issued_count=1, done_count=1, busy_o=0 after done.
- Push 4 words with unit_ready_i=0 -> instr_ready_o=0 after 4th push; 5th push ignored; release ready -> words issued in push order, 4 done pulses -> done_count=4.
- Hold unit_ready_i=0 for 10 cycles during ISSUE -> instruction_valid_o stays 1 and instruction_o unchanged for all 10 cycles; issued_count stays 0.
- Done pulse in IDLE, and again in ISSUE before the handshake -> counters unchanged, state unchanged.
- Assert reset_i while in WAIT_DONE with 2 words queued -> outputs immediately at reset values; after release, no issue until a new push.
- ISSUER_TIMEOUT_EN, TIMEOUT_CYCLES=8, no done pulse -> timeout_o=1 after 8 WAIT_DONE cycles; next queued word issued; done_count=0. Repeat with done on cycle 8 -> timeout_o=0, done_count=1.
